axi_stream_remove_header: RTL and testbench

- Downstream companion of the header-insert stage: consumes an AXI-Stream packet and removes a per-packet number of leading bytes, S.
- Re-aligns the remaining payload so every output beat is MSB-packed: full keep on all beats except the last, last beat keep contiguous from the MSB.
- S arrives once per packet on a strip side channel with valid/ready.
- Used to strip the inserted header before payload processing, and as the round-trip checker partner of the insert stage.

---
 rtl/axi_stream_remove_header.sv | 167 ++++++++++++++++
 tb/tb_axi_stream_remove_header.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_remove_header.sv
// Strips S leading bytes from each AXI-Stream packet and re-packs the
// remaining payload MSB-aligned: full beats, contiguous partial last beat.
module axi_stream_remove_header #(
  parameter int unsigned DATA_WD      = 32,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
  parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_strip,
  input  logic [BYTE_CNT_WD:0]    byte_strip_cnt,
  output logic                    ready_strip
);

  localparam int unsigned N  = DATA_BYTE_WD;
  localparam int unsigned CW = BYTE_CNT_WD + 1;
  localparam int unsigned TW = BYTE_CNT_WD + 2;

  typedef enum logic [2:0] {
    IDLE,
    FIRST,
    STREAM,
    FLUSH,
    EMIT_LAST
  } state_e;

  state_e              state_q;
  logic                alive_q;
  logic [CW-1:0]       strip_q;
  logic [CW-1:0]       rcnt_q;
  logic [DATA_WD-1:0]  res_q;
  logic                valid_out_q;
  logic                last_out_q;
  logic [DATA_WD-1:0]  data_out_q;
  logic [N-1:0]        keep_out_q;

  logic                out_free_c;
  logic                in_hs_c;
  logic                strip_hs_c;
  logic [CW-1:0]       k_in_c;
  logic [DATA_WD-1:0]  din_m_c;
  logic [DATA_WD-1:0]  first_res_c;
  logic [2*DATA_WD-1:0] cat_c;
  logic [TW-1:0]       total_c;

  function automatic logic [CW-1:0] keep_count(input logic [N-1:0] k);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < int'(N); i++) c = c + CW'(k[i]);
    return c;
  endfunction

  function automatic logic [N-1:0] keep_of(input logic [TW-1:0] cnt);
    logic [N-1:0] k;
    for (int i = 0; i < int'(N); i++) k[N-1-i] = (TW'(i) < cnt);
    return k;
  endfunction

  function automatic logic [DATA_WD-1:0] mask_data(input logic [DATA_WD-1:0] d,
                                                   input logic [N-1:0] k);
    logic [DATA_WD-1:0] m;
    for (int i = 0; i < int'(N); i++) m[8*i +: 8] = k[i] ? d[8*i +: 8] : 8'h00;
    return m;
  endfunction

  assign out_free_c  = !valid_out_q || ready_out;
  assign ready_in    = ((state_q == FIRST) || (state_q == STREAM)) && out_free_c;
  // A new packet is admitted only once the previous final beat has left.
  assign ready_strip = (state_q == IDLE) && !valid_out_q && alive_q;
  assign in_hs_c     = valid_in && ready_in;
  assign strip_hs_c  = valid_strip && ready_strip;

  assign k_in_c      = keep_count(keep_in);
  assign din_m_c     = mask_data(data_in, keep_in);
  assign first_res_c = din_m_c << {strip_q, 3'b000};
  // Residue occupies the top R bytes; the incoming beat lands right after it.
  assign cat_c       = {res_q, {DATA_WD{1'b0}}} | ({din_m_c, {DATA_WD{1'b0}}} >> {rcnt_q, 3'b000});
  assign total_c     = TW'(rcnt_q) + TW'(k_in_c);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      alive_q     <= 1'b0;
      strip_q     <= '0;
      rcnt_q      <= '0;
      res_q       <= '0;
      valid_out_q <= 1'b0;
      last_out_q  <= 1'b0;
      data_out_q  <= '0;
      keep_out_q  <= '0;
    end else begin
      alive_q <= 1'b1;
      if (valid_out_q && ready_out) valid_out_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (strip_hs_c) begin
            strip_q <= byte_strip_cnt;
            state_q <= FIRST;
          end
        end
        FIRST: begin
          if (in_hs_c) begin
            if (last_in && (k_in_c <= strip_q)) begin
              state_q <= IDLE;
            end else begin
              res_q   <= first_res_c;
              rcnt_q  <= k_in_c - strip_q;
              state_q <= last_in ? EMIT_LAST : STREAM;
            end
          end
        end
        STREAM: begin
          if (in_hs_c) begin
            if (last_in && (total_c <= TW'(N))) begin
              valid_out_q <= 1'b1;
              data_out_q  <= cat_c[2*DATA_WD-1 -: DATA_WD];
              keep_out_q  <= keep_of(total_c);
              last_out_q  <= 1'b1;
              res_q       <= '0;
              rcnt_q      <= '0;
              state_q     <= IDLE;
            end else if (total_c >= TW'(N)) begin
              valid_out_q <= 1'b1;
              data_out_q  <= cat_c[2*DATA_WD-1 -: DATA_WD];
              keep_out_q  <= '1;
              last_out_q  <= 1'b0;
              res_q       <= cat_c[DATA_WD-1:0];
              rcnt_q      <= CW'(total_c - TW'(N));
              if (last_in) state_q <= FLUSH;
            end else begin
              res_q  <= cat_c[2*DATA_WD-1 -: DATA_WD];
              rcnt_q <= CW'(total_c);
            end
          end
        end
        FLUSH, EMIT_LAST: begin
          if (out_free_c) begin
            valid_out_q <= 1'b1;
            data_out_q  <= res_q;
            keep_out_q  <= keep_of(TW'(rcnt_q));
            last_out_q  <= 1'b1;
            res_q       <= '0;
            rcnt_q      <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign valid_out = valid_out_q;
  assign data_out  = data_out_q;
  assign keep_out  = keep_out_q;
  assign last_out  = last_out_q;

endmodule

// File: tb/tb_axi_stream_remove_header.sv
// Self-checking bench: byte-level reference model of header stripping,
// directed literal cases plus randomized back-to-back traffic.
module tb_axi_stream_remove_header;

  localparam int unsigned DATA_WD = 32;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        drop;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] data_in = '0;
  logic [3:0]  keep_in = '0;
  logic        last_in = 1'b0;
  logic        ready_in;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out = 1'b0;
  logic        valid_strip = 1'b0;
  logic [2:0]  byte_strip_cnt = '0;
  logic        ready_strip;

  axi_stream_remove_header #(.DATA_WD(DATA_WD)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_in       (valid_in),
    .data_in        (data_in),
    .keep_in        (keep_in),
    .last_in        (last_in),
    .ready_in       (ready_in),
    .valid_out      (valid_out),
    .data_out       (data_out),
    .keep_out       (keep_out),
    .last_out       (last_out),
    .ready_out      (ready_out),
    .valid_strip    (valid_strip),
    .byte_strip_cnt (byte_strip_cnt),
    .ready_strip    (ready_strip)
  );

  always #5 clk = ~clk;

  beat_t bq[$];
  beat_t exq[$];
  int    sq[$];
  int    checks = 0;
  int    errors = 0;
  int    stall_cnt = 0;
  int    in_hs_cnt = 0;
  bit    stall_on_valid = 0;
  bit    rdy_rand = 0, in_rand = 0, strip_hold = 0;
  bit    pend_rin = 0, pend_rs = 0, in_clr = 0, st_clr = 0;
  bit    prev_hold = 0;
  logic [36:0] prev_out;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: drop the first s bytes, re-chunk the rest into 4-byte beats.
  task automatic model(input int s, input byte unsigned b[$], output beat_t o[$]);
    beat_t e;
    int    n;
    o = {};
    e = '0;
    n = 0;
    for (int i = s; i < b.size(); i++) begin
      e.data[31-8*n -: 8] = b[i];
      e.keep[3-n] = 1'b1;
      n++;
      if (n == 4 || i == b.size() - 1) begin
        e.last = (i == b.size() - 1);
        o.push_back(e);
        e = '0;
        n = 0;
      end
    end
  endtask

  task automatic build(input int s, input byte unsigned b[$], input bit use_model);
    beat_t bt;
    beat_t o[$];
    int    nb;
    int    idx;
    nb = (b.size() + 3) / 4;
    for (int j = 0; j < nb; j++) begin
      bt = '0;
      for (int i = 0; i < 4; i++) begin
        idx = 4*j + i;
        if (idx < b.size()) begin
          bt.data[31-8*i -: 8] = b[idx];
          bt.keep[3-i] = 1'b1;
        end else begin
          bt.data[31-8*i -: 8] = 8'($urandom);
        end
      end
      bt.last = (j == nb - 1);
      bt.drop = bt.last && (b.size() <= s);
      bq.push_back(bt);
    end
    sq.push_back(s);
    if (use_model) begin
      model(s, b, o);
      foreach (o[k]) exq.push_back(o[k]);
    end
  endtask

  task automatic exp_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    beat_t e;
    e = '{data: d, keep: k, last: l, drop: 1'b0};
    exq.push_back(e);
  endtask

  task automatic sample();
    beat_t e;
    if (pend_rin) begin chk("ready_in_after_last", 64'(ready_in), 64'd0); pend_rin = 0; end
    if (pend_rs) begin chk("ready_strip_after_drop", 64'(ready_strip), 64'd1); pend_rs = 0; end
    if (prev_hold) chk("hold_stable", {valid_out, data_out, keep_out, last_out}, {1'b1, prev_out});
    if (valid_out && !ready_out) chk("ready_in_while_stalled", 64'(ready_in), 64'd0);
    if (valid_out) begin
      if (exq.size() == 0) begin
        chk("unexpected_output", {data_out, keep_out, last_out}, 64'd0);
        if (!({data_out, keep_out, last_out} !== 37'd0)) begin
          errors++;
          $display("FAIL unexpected_output actual=valid required=idle t=%0t", $time);
        end
      end else if (ready_out) begin
        e = exq.pop_front();
        chk("out_beat", {data_out, keep_out, last_out}, {e.data, e.keep, e.last});
      end
    end
    prev_hold = valid_out && !ready_out;
    prev_out  = {data_out, keep_out, last_out};
    if (valid_in && ready_in) begin
      in_hs_cnt++;
      if (last_in) begin
        pend_rin = 1;
        pend_rs  = bq[0].drop;
      end
      void'(bq.pop_front());
      in_clr = 1;
    end
    if (valid_strip && ready_strip) begin
      void'(sq.pop_front());
      st_clr = 1;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    if (in_clr) begin valid_in = 1'b0; in_clr = 0; end
    if (st_clr) begin valid_strip = 1'b0; st_clr = 0; end
    if (stall_on_valid && valid_out) begin stall_cnt = 5; stall_on_valid = 0; end
    if (stall_cnt > 0) begin
      ready_out = 1'b0;
      stall_cnt--;
    end else begin
      ready_out = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    if (!valid_strip && sq.size() > 0 && (strip_hold || $urandom_range(0, 1) == 1)) begin
      valid_strip = 1'b1;
      byte_strip_cnt = 3'(sq[0]);
    end
    if (!valid_in && bq.size() > 0 && (!in_rand || $urandom_range(0, 1) == 1)) begin
      valid_in = 1'b1;
      data_in  = bq[0].data;
      keep_in  = bq[0].keep;
      last_in  = bq[0].last;
    end
    #2;
    sample();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((bq.size() != 0 || sq.size() != 0 || exq.size() != 0 || valid_in || valid_strip ||
            valid_out || pend_rin || pend_rs) && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d cycles required<%0d", n, budget);
    end
    repeat (2) cycle();
  endtask

  initial begin
    byte unsigned b[$];
    beat_t       o[$];

    // Power-on reset state.
    repeat (3) @(negedge clk);
    #2;
    chk("rst_valid_out", 64'(valid_out), 64'd0);
    chk("rst_ready_in", 64'(ready_in), 64'd0);
    chk("rst_ready_strip", 64'(ready_strip), 64'd0);
    chk("rst_out_regs", {data_out, keep_out, last_out}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Pin the reference model to hand-derived beats.
    b = {};
    for (int i = 0; i < 10; i++) b.push_back(8'(i));
    model(2, b, o);
    chk("model_nbeats", 64'(o.size()), 64'd2);
    if (o.size() == 2) begin
      chk("model_beat0", 64'(o[0]), 64'({32'h02030405, 4'hF, 1'b0, 1'b0}));
      chk("model_beat1", 64'(o[1]), 64'({32'h06070809, 4'hF, 1'b1, 1'b0}));
    end

    // S=2 over three beats: two full output beats, no flush.
    build(2, b, 0);
    exp_beat(32'h02030405, 4'hF, 1'b0);
    exp_beat(32'h06070809, 4'hF, 1'b1);
    drain(200);

    // S=1: extra flush beat at the end.
    b = {};
    for (int i = 0; i < 7; i++) b.push_back(8'((i + 1) * 8'h11));
    build(1, b, 0);
    exp_beat(32'h22334455, 4'hF, 1'b0);
    exp_beat(32'h66770000, 4'hC, 1'b1);
    drain(200);

    // S=0 single byte, then two fully dropped packets.
    b = {};
    b.push_back(8'hDE);
    build(0, b, 0);
    exp_beat(32'hDE000000, 4'h8, 1'b1);
    b = {};
    for (int i = 0; i < 4; i++) b.push_back(8'($urandom));
    build(4, b, 0);
    b = {};
    for (int i = 0; i < 2; i++) b.push_back(8'($urandom));
    build(3, b, 0);
    drain(200);

    // Six-beat packet with a five-cycle downstream stall.
    b = {};
    for (int i = 0; i < 22; i++) b.push_back(8'($urandom));
    stall_on_valid = 1;
    build(2, b, 1);
    drain(400);

    // Reset in the middle of a packet after two beats.
    b = {};
    for (int i = 0; i < 16; i++) b.push_back(8'(i));
    build(2, b, 0);
    void'(bq.pop_back());
    void'(bq.pop_back());
    exp_beat(32'h02030405, 4'hF, 1'b0);
    in_hs_cnt = 0;
    for (int n = 0; n < 100 && in_hs_cnt < 2; n++) cycle();
    chk("reset_test_inputs_taken", 64'(in_hs_cnt), 64'd2);
    cycle();
    @(negedge clk);
    rst_n = 1'b0;
    valid_in = 1'b0;
    valid_strip = 1'b0;
    in_clr = 0; st_clr = 0; pend_rin = 0; pend_rs = 0; prev_hold = 0;
    bq = {}; sq = {}; exq = {};
    @(posedge clk);
    #2;
    chk("midrst_valid_out", 64'(valid_out), 64'd0);
    chk("midrst_ready_strip", 64'(ready_strip), 64'd0);
    chk("midrst_ready_in", 64'(ready_in), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    b = {};
    for (int i = 0; i < 9; i++) b.push_back(8'($urandom));
    build(1, b, 1);
    drain(200);

    // Back-to-back random traffic.
    strip_hold = 1; in_rand = 1; rdy_rand = 1;
    for (int p = 0; p < 40; p++) begin
      int s;
      int len;
      s = int'($urandom_range(0, 4));
      len = int'($urandom_range(1, 20));
      b = {};
      for (int i = 0; i < len; i++) b.push_back(8'($urandom));
      build(s, b, 1);
    end
    drain(20000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
